// File: rtl/plugin_dispatch.sv
// Issue/writeback controller between the RS5 execute stage and a start/busy/done
// plugin accelerator: decode, operand capture, watchdog, flush draining, writeback.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no plugin op in flight; capture operands/rd on a match
// S_ISSUE | waiting for the plugin to be free, then pulse plug_start
// S_WAIT  | start issued, waiting for plug_done or watchdog expiry
// S_RESP  | one-cycle writeback of result / timeout error
// S_DRAIN | op was flushed after start; swallow the plugin's done
module plugin_dispatch #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exe_valid,
  input  logic [31:0] exe_instr,
  input  logic [31:0] exe_rs1,
  input  logic [31:0] exe_rs2,
  input  logic        flush,
  output logic        hold,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        plug_err,
  output logic        plug_start,
  output logic [31:0] plug_operand_a,
  output logic [31:0] plug_operand_b,
  input  logic        plug_busy,
  input  logic        plug_done,
  input  logic [31:0] plug_result
);

  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [31:0]    r_op_a;
  logic [31:0]    r_op_b;
  logic [31:0]    r_result;
  logic [4:0]     r_rd;
  logic           r_err;
  logic [WDW-1:0] r_wdog;

  logic w_match;
  logic w_expire;
  logic w_start;
  logic w_capture;
  logic w_take;
  logic w_timeout;
  logic w_counting;
  logic w_unused;

  assign w_match = exe_valid && (exe_instr[6:0] == 7'b0001011) &&
                   (exe_instr[14:12] == 3'b000) && (exe_instr[31:25] == 7'b0000000);

  // Down-counter reaching zero marks the last cycle the op may occupy ISSUE/WAIT.
  assign w_expire   = (r_wdog == '0);
  assign w_counting = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_unused   = ^exe_instr[24:15];

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_take    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_match && !flush) begin
          w_capture = 1'b1;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start = !plug_busy && !plug_done && !w_expire;
        if (flush) begin
          // A start driven this cycle has already reached the plugin, so drain it.
          w_next = w_start ? S_DRAIN : S_IDLE;
        end else if (w_start) begin
          w_next = S_WAIT;
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_next = S_DRAIN;
        end else if (plug_done) begin
          w_take = 1'b1;
          w_next = S_RESP;
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (plug_done || w_expire) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_wdog   <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_op_a <= exe_rs1;
        r_op_b <= exe_rs2;
        r_rd   <= exe_instr[11:7];
        r_wdog <= WD_LOAD;
      end else if (w_counting && !w_expire) begin
        r_wdog <= r_wdog - 1'b1;
      end
      if (w_capture || w_take) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_take) begin
        r_result <= plug_result;
      end else if (w_timeout) begin
        r_result <= 32'hFFFF_FFFF;
      end
    end
  end

  assign hold = (w_match && ((r_state == S_IDLE) || (r_state == S_DRAIN))) ||
                (r_state == S_ISSUE) || (r_state == S_WAIT);

  // A flush landing on the response cycle kills the writeback and its error.
  assign wb_valid       = (r_state == S_RESP) && (r_rd != 5'd0) && !flush;
  assign plug_err       = (r_state == S_RESP) && r_err && !flush;
  assign wb_rd          = r_rd;
  assign wb_data        = r_result;
  assign plug_start     = w_start;
  assign plug_operand_a = r_op_a;
  assign plug_operand_b = r_op_b;

endmodule

// File: tb/tb_plugin_dispatch.sv
// Bench for plugin_dispatch: decode table, directed multi-cycle sequences and
// randomized ops checked against a cycle-arithmetic model of the dispatch rules.
module tb_plugin_dispatch;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        exe_valid = 1'b0;
  logic [31:0] exe_instr = '0;
  logic [31:0] exe_rs1 = '0;
  logic [31:0] exe_rs2 = '0;
  logic        flush = 1'b0;
  logic        hold;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        plug_err;
  logic        plug_start;
  logic [31:0] plug_operand_a;
  logic [31:0] plug_operand_b;
  logic        plug_busy = 1'b0;
  logic        plug_done = 1'b0;
  logic [31:0] plug_result = '0;

  always #5 clk = ~clk;

  plugin_dispatch #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .exe_valid(exe_valid), .exe_instr(exe_instr), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
    .flush(flush), .hold(hold),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .plug_err(plug_err),
    .plug_start(plug_start), .plug_operand_a(plug_operand_a), .plug_operand_b(plug_operand_b),
    .plug_busy(plug_busy), .plug_done(plug_done), .plug_result(plug_result)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc_n = 0;

  // Plugin model: done arrives p_lat cycles after start, busy in between.
  int          p_start = -1;
  int          p_done_at = -1;
  int          p_lat = 1;
  logic [31:0] p_res = '0;
  bit          p_never = 0;
  int          ext_lo = 0;
  int          ext_hi = 0;
  bit          prev_start = 0;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        exp_hold;
  } vec_t;
  vec_t vt[9];

  function automatic logic [31:0] plug_instr(input logic [4:0] rd);
    return {7'b0000000, 5'd2, 5'd1, 3'b000, rd, 7'b0001011};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0b want %0b at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic fl);
    @(negedge clk);
    cyc_n++;
    exe_valid   = v;
    exe_instr   = instr;
    exe_rs1     = rs1;
    exe_rs2     = rs2;
    flush       = fl;
    plug_done   = (cyc_n == p_done_at);
    plug_busy   = (p_start >= 0 && cyc_n > p_start && cyc_n < p_done_at) ||
                  (cyc_n >= ext_lo && cyc_n < ext_hi);
    plug_result = plug_done ? p_res : 32'hDEAD_BEEF;
    #1;
    if (plug_start) begin
      chk1("start_not_back_to_back", prev_start, 1'b0);
      p_start   = cyc_n;
      p_done_at = cyc_n + (p_never ? 100000 : p_lat);
    end
    prev_start = plug_start;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_hold"}, hold, 1'b0);
    chk1({tag, "_wbv"}, wb_valid, 1'b0);
    chk32({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    chk32({tag, "_wbdata"}, wb_data, 32'd0);
    chk1({tag, "_err"}, plug_err, 1'b0);
    chk1({tag, "_start"}, plug_start, 1'b0);
    chk32({tag, "_opa"}, plug_operand_a, 32'd0);
    chk32({tag, "_opb"}, plug_operand_b, 32'd0);
  endtask

  logic        pend;
  logic [4:0]  t_rd;
  logic [31:0] t_rs1, t_rs2, t_res, junk;
  int          t_lat, t_b, t_gap, t_s, t_d, exp_k, n_st, n_ev, base;
  bit          exp_to;

  initial begin
    vt[0] = '{1'b1, plug_instr(5'd5), 1'b1};
    vt[1] = '{1'b0, plug_instr(5'd5), 1'b0};
    vt[2] = '{1'b1, {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0001111}, 1'b0};
    vt[3] = '{1'b1, {7'b0000000, 5'd2, 5'd1, 3'b001, 5'd5, 7'b0001011}, 1'b0};
    vt[4] = '{1'b1, {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0001011}, 1'b0};
    vt[5] = '{1'b1, {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0001011}, 1'b0};
    vt[6] = '{1'b1, {7'b0000000, 5'd31, 5'd31, 3'b000, 5'd31, 7'b0001011}, 1'b1};
    vt[7] = '{1'b1, {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0101011}, 1'b0};
    vt[8] = '{1'b1, {7'b0000000, 5'd2, 5'd1, 3'b100, 5'd5, 7'b0001011}, 1'b0};

    #1;
    chk_all_zero("reset");
    repeat (2) step(1'b0, '0, '0, '0, 1'b0);
    reset_n = 1'b1;

    // Decode table: flush held so the FSM stays in IDLE and hold reflects the match.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].v, vt[i].instr, 32'h1234, 32'h5678, 1'b1);
      chk1("dec_hold", hold, vt[i].exp_hold);
      chk1("dec_no_start", plug_start, 1'b0);
    end
    step(1'b0, '0, '0, '0, 1'b0);
    chk1("dec_idle_after_flush", hold, 1'b0);

    // Basic op: rs1=10, rd=5, result 55 after 8 cycles.
    p_never = 0; p_lat = 8; p_res = 32'd55; pend = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step(pend, plug_instr(5'd5), 32'd10, 32'd3, 1'b0);
      chk1("t1_start", plug_start, k == 1);
      chk1("t1_hold", hold, k <= 9);
      chk1("t1_wbv", wb_valid, k == 10);
      chk1("t1_err", plug_err, 1'b0);
      if (k == 1) chk32("t1_op_a", plug_operand_a, 32'd10);
      if (k == 10) begin
        chk32("t1_wbrd", {27'd0, wb_rd}, 32'd5);
        chk32("t1_wbdata", wb_data, 32'd55);
      end
      if (!hold) pend = 1'b0;
    end

    // rd=0 issued back-to-back right after the previous RESP.
    p_lat = 8; p_res = 32'd1; pend = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step(pend, plug_instr(5'd0), 32'd10, 32'd3, 1'b0);
      chk1("t2_start", plug_start, k == 1);
      chk1("t2_hold", hold, k <= 9);
      chk1("t2_wbv", wb_valid, 1'b0);
      chk1("t2_err", plug_err, 1'b0);
      if (!hold) pend = 1'b0;
    end

    // Plugin never completes: timeout response at cycle T+1, then a stale done.
    p_never = 1; pend = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step(pend, plug_instr(5'd7), 32'd4, 32'd4, 1'b0);
      chk1("t3_start", plug_start, k == 1);
      chk1("t3_hold", hold, k <= T);
      chk1("t3_wbv", wb_valid, k == T + 1);
      chk1("t3_err", plug_err, k == T + 1);
      if (k == T + 1) begin
        chk32("t3_wbrd", {27'd0, wb_rd}, 32'd7);
        chk32("t3_wbdata", wb_data, 32'hFFFF_FFFF);
      end
      if (!hold) pend = 1'b0;
    end
    p_never = 0; p_res = 32'd99; p_done_at = cyc_n + 2;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, '0, '0, 1'b0);
      chk1("t3_stale_wbv", wb_valid, 1'b0);
      chk1("t3_stale_err", plug_err, 1'b0);
      chk1("t3_stale_start", plug_start, 1'b0);
    end

    // Flush in WAIT at cycle 4, drain until done at 9; next op starts at 11.
    p_lat = 8; p_res = 32'd111; pend = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      if (k == 10) p_res = 32'd222;
      step((k < 5) ? 1'b1 : pend, (k < 5) ? plug_instr(5'd3) : plug_instr(5'd4),
           (k < 5) ? 32'h0000_000A : 32'h0000_0B0B, 32'd1, k == 4);
      chk1("t4_start", plug_start, (k == 1) || (k == 11));
      chk1("t4_hold", hold, k <= 19);
      chk1("t4_wbv", wb_valid, k == 20);
      if (k == 11) chk32("t4_op_a", plug_operand_a, 32'h0000_0B0B);
      if (k == 20) begin
        chk32("t4_wbrd", {27'd0, wb_rd}, 32'd4);
        chk32("t4_wbdata", wb_data, 32'd222);
      end
      if (k >= 5 && !hold) pend = 1'b0;
    end

    // Plugin busy for 3 cycles on ISSUE entry delays the single start to cycle 4.
    base = cyc_n + 1; ext_lo = base + 1; ext_hi = base + 4;
    p_lat = 4; p_res = 32'd77; pend = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step(pend, plug_instr(5'd9), 32'd8, 32'd9, 1'b0);
      chk1("t5_start", plug_start, k == 4);
      chk1("t5_hold", hold, k <= 8);
      chk1("t5_wbv", wb_valid, k == 9);
      if (k == 9) chk32("t5_wbdata", wb_data, 32'd77);
      if (!hold) pend = 1'b0;
    end
    ext_lo = 0; ext_hi = 0;

    // Reset while in WAIT: outputs clear at once, no writeback afterwards.
    p_never = 1;
    for (int k = 0; k <= 5; k++) step(1'b1, plug_instr(5'd6), 32'hCAFE, 32'hF00D, 1'b0);
    reset_n = 1'b0;
    exe_valid = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    repeat (2) step(1'b0, '0, '0, '0, 1'b0);
    reset_n = 1'b1;
    p_never = 0; p_done_at = cyc_n + 4;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, '0, '0, 1'b0);
      chk1("t6_wbv", wb_valid, 1'b0);
      chk1("t6_err", plug_err, 1'b0);
      chk1("t6_start", plug_start, 1'b0);
    end

    // Randomized ops: expected start/response cycle from plain arithmetic.
    for (int op = 0; op < 40; op++) begin
      t_rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) t_rd = 5'd0;
      t_rs1 = $urandom; t_rs2 = $urandom; t_res = $urandom;
      t_lat = $urandom_range(1, 20);
      t_b   = $urandom_range(0, 3);
      t_gap = $urandom_range(0, 3);
      for (int g = 0; g < t_gap; g++) begin
        junk = $urandom;
        junk[6:0] = 7'b0001011;
        junk[14:12] = 3'($urandom_range(1, 7));
        step(1'b1, junk, $urandom, $urandom, 1'b0);
        chk1("rnd_junk_start", plug_start, 1'b0);
        chk1("rnd_junk_hold", hold, 1'b0);
      end
      t_s    = 1 + t_b;
      t_d    = t_s + t_lat;
      exp_to = (t_d > T);
      exp_k  = exp_to ? T + 1 : t_d + 1;
      base = cyc_n + 1; ext_lo = base + 1; ext_hi = base + 1 + t_b;
      p_lat = t_lat; p_res = t_res;
      pend = 1'b1; n_st = 0; n_ev = 0;
      for (int k = 0; k <= T + 2; k++) begin
        step(pend, plug_instr(t_rd), t_rs1, t_rs2, 1'b0);
        if (plug_start) begin
          n_st++;
          chk32("rnd_start_cycle", k, t_s);
          chk32("rnd_op_a", plug_operand_a, t_rs1);
          chk32("rnd_op_b", plug_operand_b, t_rs2);
        end
        if (wb_valid || plug_err) begin
          n_ev++;
          chk32("rnd_resp_cycle", k, exp_k);
          chk1("rnd_wbv", wb_valid, t_rd != 5'd0);
          chk1("rnd_err", plug_err, exp_to);
          if (wb_valid) begin
            chk32("rnd_wbrd", {27'd0, wb_rd}, {27'd0, t_rd});
            chk32("rnd_wbdata", wb_data, exp_to ? 32'hFFFF_FFFF : t_res);
          end
        end
        if (!hold) pend = 1'b0;
      end
      chk32("rnd_n_start", n_st, 1);
      chk32("rnd_n_resp", n_ev, ((t_rd != 5'd0) || exp_to) ? 1 : 0);
      ext_lo = 0; ext_hi = 0;
      for (int w = 0; w < 40 && cyc_n <= p_done_at; w++) begin
        step(1'b0, '0, '0, '0, 1'b0);
        chk1("rnd_late_done_ignored", wb_valid || plug_err, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got timeout want finish at cycle %0d", cyc_n);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/plugin_dispatch.md
# plugin_dispatch

Issue/writeback controller between the RS5 execute stage and a multi-cycle start/busy/done plugin accelerator (e.g. the Fibonacci plugin). It decodes the custom-0 plugin instruction and stalls the pipeline. It registers operands, pulses `plug_start`, waits for `plug_done` under a watchdog, and returns the result as a one-cycle writeback. Flushes are handled by draining the plugin, which has no abort input.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles spent in ISSUE+WAIT before the operation is abandoned; must be ≥ 2.
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `exe_valid`  in  1  execute stage holds a valid instruction.
- `exe_instr`  in  32  instruction word.
- `exe_rs1`, `exe_rs2`  in  32 each  source operand values.
- `flush`  in  1  pipeline flush; kills the current plugin instruction.
- `hold`  out  1  stall execute stage (combinational).
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  writeback value.
- `plug_err`  out  1  one-cycle timeout pulse, aligned with its `wb_valid`.
- `plug_start`  out  1  start pulse to plugin.
- `plug_operand_a`, `plug_operand_b`  out  32 each  registered rs1/rs2.
- `plug_busy`, `plug_done`  in  1 each  plugin status.
- `plug_result`  in  32  plugin result; valid when `plug_done`=1.

## Operation
- Match: `exe_valid` & opcode[6:0]=7'b0001011 & funct3=3'b000 & funct7=7'b0000000. Any other encoding is ignored.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - match & !flush → ISSUE.
  - Capture rs1/rs2 into the operand registers, rd into the rd register, clear the watchdog.
- ISSUE:
  - `plug_start`=1 only when `plug_busy`=0 and `plug_done`=0; otherwise stay in ISSUE with `plug_start`=0.
  - → WAIT the cycle after `plug_start`=1 was driven.
- WAIT:
  - `plug_done`=1 → capture `plug_result`, → RESP.
  - Watchdog is counted in ISSUE and WAIT. When it reaches TIMEOUT_CYCLES, load 32'hFFFF_FFFF as result, set the error flag, → RESP.
- RESP (one cycle):
  - `wb_valid`=1 if rd≠0; `wb_data`=captured result; `plug_err`=error flag. → IDLE.
  - rd=0 completes normally with `wb_valid`=0; `plug_err` still pulses on timeout.
- Flush:
  - In ISSUE before start issued → IDLE.
  - In ISSUE after start, or in WAIT → DRAIN.
  - In RESP → `wb_valid`/`plug_err` suppressed, → IDLE.
  - In IDLE → no capture.
- DRAIN: wait for `plug_done`, discard result, → IDLE. Watchdog still counts; expiry → IDLE silently.
- `plug_done` is ignored in IDLE and RESP. A late done after a timeout is discarded.
- `hold` = match & state∈{IDLE, DRAIN}, or state∈{ISSUE, WAIT}. `hold`=0 in RESP so the pipeline advances with the writeback.
- Operands are stable from ISSUE through RESP. The operand/rd registers are written only in IDLE.

## Timing
- Reset values (async): state IDLE; `hold` follows its combinational definition; `wb_valid`, `wb_rd`, `wb_data`, `plug_err`, `plug_start`, `plug_operand_a`, `plug_operand_b`, watchdog and error flag all 0.
- Cycle 0: match in IDLE, `hold`=1.
- Cycle 1: ISSUE, `plug_start`=1 (plugin idle).
- Cycle 1+L: `plug_done` seen, where L is the plugin start→done latency.
- Cycle 2+L: RESP, `wb_valid`=1, `hold`=0.
- Back-to-back plugin instructions: next match is accepted the cycle after RESP.
- `plug_start` is never high for two consecutive cycles.
- Reset mid-operation returns to IDLE immediately; no writeback.

## Test plan
- exe_rs1=10, rd=5, plugin returns 55 after 8 cycles → `plug_start` one pulse at cycle 1; `wb_valid` at cycle 10 with `wb_rd`=5, `wb_data`=55; `hold` high cycles 0–9.
- Same instruction with rd=0, result 1 → no `wb_valid`; `hold` drops in RESP; FSM back to IDLE.
- Plugin never asserts done, TIMEOUT_CYCLES=16 → RESP at cycle 17 with `wb_data`=32'hFFFF_FFFF, `plug_err`=1 for one cycle. A later stale `plug_done` is ignored.
- `flush` in WAIT at cycle 4, done at cycle 9 → no `wb_valid`. A new plugin instruction presented at cycle 5 holds until IDLE, then its `plug_start` issues at cycle 11.
- `plug_busy`=1 on entry to ISSUE for 3 cycles → `plug_start` delayed 3 cycles, then a single pulse.
- `reset_n` low in WAIT → all outputs 0 asynchronously; no writeback after release.
